// File: rtl/fifo18_to_gmii.sv
// Drains 18-bit frame words from a FWFT FIFO onto GMII TX: header -> preamble/SFD, IFG, underrun abort.
// Optional TIMED_LAUNCH_EN: hold each frame in WAIT until global_counter >= header timestamp.
module fifo18_to_gmii #(
   parameter logic [3:0] IFG_CYCLES = 4'd12
) (
   input  logic        gmii_tx_clk,
   input  logic        sys_rst_n,
   input  logic [63:0] global_counter,
   input  logic [17:0] dout,
   input  logic        empty,
   output logic        rd_en,
   output logic        rd_clk,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic [7:0]  gmii_txd,
   output logic [7:0]  tx_count,
   output logic [7:0]  underrun_count
);

   typedef enum logic [2:0] {IDLE, HDR, WAIT, PRE, DATAH, DATAL, DRAIN, IFG} state_t;

   localparam logic [3:0] IFG_LOAD = (IFG_CYCLES > 4'd1) ? IFG_CYCLES - 4'd1 : 4'd0;

   state_t      state, state_d;
   logic [1:0]  hdr_idx, hdr_idx_d;
   logic [2:0]  pre_cnt, pre_cnt_d;
   logic [3:0]  ifg_cnt, ifg_cnt_d;
   logic        tx_en_p0, tx_er_p0;
   logic [7:0]  txd_p0;
   logic        inc_tx, inc_ur;
   logic        launch_ok;
   logic [1:0]  code;

   assign code   = dout[17:16];
   assign rd_clk = gmii_tx_clk;

`ifdef TIMED_LAUNCH_EN
   logic [63:0] launch_ts;

   // header word n carries ts[16n+7:16n] in the hi byte and ts[16n+15:16n+8] in the lo byte
   always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         launch_ts <= '0;
      else if (state == HDR && !empty && code == 2'b11)
         launch_ts[{hdr_idx, 4'd0} +: 16] <= {dout[7:0], dout[15:8]};
   end

   assign launch_ok = (global_counter >= launch_ts);
`else
   logic unused_gc;
   assign unused_gc = ^global_counter;
   assign launch_ok = 1'b1;
`endif

   always_comb begin
      state_d   = state;
      hdr_idx_d = hdr_idx;
      pre_cnt_d = pre_cnt;
      ifg_cnt_d = ifg_cnt;
      rd_en     = 1'b0;
      tx_en_p0  = 1'b0;
      tx_er_p0  = 1'b0;
      txd_p0    = 8'h00;
      inc_tx    = 1'b0;
      inc_ur    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_d   = HDR;
               hdr_idx_d = 2'd0;
            end
         end
         HDR: begin
            // words without code 11 are stray and get dropped without advancing
            if (!empty) begin
               rd_en = 1'b1;
               if (code == 2'b11) begin
                  hdr_idx_d = hdr_idx + 2'd1;
                  if (hdr_idx == 2'd3) state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!empty && launch_ok) begin
               state_d   = PRE;
               pre_cnt_d = 3'd0;
            end
         end
         PRE: begin
            tx_en_p0  = 1'b1;
            txd_p0    = (pre_cnt == 3'd7) ? 8'hD5 : 8'h55;
            pre_cnt_d = pre_cnt + 3'd1;
            if (pre_cnt == 3'd7) state_d = DATAH;
         end
         DATAH: begin
            if (empty) begin
               tx_en_p0 = 1'b1;
               tx_er_p0 = 1'b1;
               inc_ur   = 1'b1;
               state_d  = DRAIN;
            end else if (code == 2'b11) begin
               tx_en_p0 = 1'b1;
               txd_p0   = dout[15:8];
               state_d  = DATAL;
            end else if (code == 2'b10) begin
               tx_en_p0 = 1'b1;
               txd_p0   = dout[15:8];
               rd_en    = 1'b1;
            end else begin
               rd_en     = 1'b1;
               inc_tx    = 1'b1;
               ifg_cnt_d = IFG_LOAD;
               state_d   = IFG;
            end
         end
         DATAL: begin
            tx_en_p0 = 1'b1;
            txd_p0   = dout[7:0];
            rd_en    = !empty;
            state_d  = DATAH;
         end
         DRAIN: begin
            if (!empty) begin
               rd_en = 1'b1;
               if (code == 2'b00) begin
                  ifg_cnt_d = IFG_LOAD;
                  state_d   = IFG;
               end
            end
         end
         IFG: begin
            if (ifg_cnt == 4'd0) state_d = IDLE;
            else                 ifg_cnt_d = ifg_cnt - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // stage boundary: state and GMII outputs register together
   always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state          <= IDLE;
         hdr_idx        <= 2'd0;
         pre_cnt        <= 3'd0;
         ifg_cnt        <= 4'd0;
         gmii_tx_en     <= 1'b0;
         gmii_tx_er     <= 1'b0;
         gmii_txd       <= 8'h00;
         tx_count       <= 8'd0;
         underrun_count <= 8'd0;
      end else begin
         state      <= state_d;
         hdr_idx    <= hdr_idx_d;
         pre_cnt    <= pre_cnt_d;
         ifg_cnt    <= ifg_cnt_d;
         gmii_tx_en <= tx_en_p0;
         gmii_tx_er <= tx_er_p0;
         gmii_txd   <= txd_p0;
         if (inc_tx) tx_count <= tx_count + 8'd1;
         if (inc_ur && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_fifo18_to_gmii.sv
// Bench for fifo18_to_gmii: queue-based FWFT FIFO, wire-stream scoreboard, frame table plus random frames.
module tb_fifo18_to_gmii;
   localparam logic [3:0] IFG = 4'd12;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] gc = 64'd0;
   logic [17:0] dout = 18'h0;
   logic        empty = 1'b1;
   logic        rd_en, rd_clk, tx_en, tx_er;
   logic [7:0]  txd, tx_count, underrun_count;

   always #4 clk = ~clk;

   fifo18_to_gmii #(.IFG_CYCLES(IFG)) dut (
      .gmii_tx_clk(clk), .sys_rst_n(rst_n), .global_counter(gc), .dout(dout), .empty(empty),
      .rd_en(rd_en), .rd_clk(rd_clk), .gmii_tx_en(tx_en), .gmii_tx_er(tx_er), .gmii_txd(txd),
      .tx_count(tx_count), .underrun_count(underrun_count));

   int n_checks = 0;
   int n_fail   = 0;

   logic [17:0] fifo_q[$];
   logic [17:0] push_q[$];
   logic [17:0] w_q[$];
   logic [7:0]  b_q[$];
   logic [9:0]  exp_q[$];   // [9]=end of burst, [8]=tx_er, [7:0]=txd
   logic [7:0]  good_cnt = 8'd0;
   logic [7:0]  ur_cnt   = 8'd0;
   bit          gc_set = 1'b0;
   logic [63:0] gc_val = 64'd0;

   // FWFT FIFO model: pop on rd_en, visible head updates after the edge
   always @(posedge clk) begin
      if (rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      empty <= (fifo_q.size() == 0);
      dout  <= (fifo_q.size() > 0) ? fifo_q[0] : 18'h0;
      if (gc_set) begin
         gc <= gc_val;
         gc_set = 1'b0;
      end else begin
         gc <= gc + 64'd1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   bit mon_on = 1'b0;
   bit prev_en = 1'b0;
   bit seen_burst = 1'b0;
   int gap = 0;
   int last_gap = -1;

   always @(negedge clk) begin
      if (!mon_on) begin
         prev_en    = 1'b0;
         gap        = 0;
         seen_burst = 1'b0;
      end else begin
         if (rd_en) check("rd_en_when_empty", 64'(empty), 64'd0);
         if (tx_en) begin
            if (!prev_en) begin
               last_gap = gap;
               if (seen_burst) check("ifg_min", 64'(gap >= int'(IFG)), 64'd1);
               seen_burst = 1'b1;
            end
            if (exp_q.size() == 0 || exp_q[0][9]) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_tx: got en=1 er=%0b txd=%02h, expected no transmit", tx_er, txd);
            end else begin
               check("wire_er_txd", 64'({tx_er, txd}), 64'(exp_q.pop_front() & 10'h1FF));
            end
         end else begin
            if (tx_er) begin
               n_checks++;
               n_fail++;
               $display("FAIL tx_er_idle: got tx_er=1 with tx_en=0, expected 0");
            end
            if (prev_en) begin
               gap = 0;
               check("burst_end", 64'(exp_q.size() > 0 && exp_q[0][9]), 64'd1);
               if (exp_q.size() > 0 && exp_q[0][9]) void'(exp_q.pop_front());
            end
            gap++;
         end
         prev_en = tx_en;
      end
   end

   function automatic logic [63:0] rand_ts();
`ifdef TIMED_LAUNCH_EN
      return 64'd0;
`else
      return {$urandom, $urandom};
`endif
   endfunction

   // queue the expected wire image of the frame in w_q/b_q, then feed header and words
   task automatic send(input logic [63:0] ts, input bit ur, input int dly_max);
      for (int i = 0; i < 7; i++) exp_q.push_back(10'h055);
      exp_q.push_back(10'h0D5);
      foreach (b_q[i]) exp_q.push_back({2'b00, b_q[i]});
      if (ur) exp_q.push_back(10'h100);
      exp_q.push_back(10'h200);
      if (ur) ur_cnt = (ur_cnt == 8'hFF) ? 8'hFF : ur_cnt + 8'd1;
      else    good_cnt = good_cnt + 8'd1;
      for (int n = 0; n < 4; n++) begin
         push_q.push_back({2'b11, ts[16*n +: 8], ts[16*n+8 +: 8]});
         if (dly_max > 0) repeat ($urandom_range(0, dly_max)) @(negedge clk);
      end
      foreach (w_q[i]) push_q.push_back(w_q[i]);
      w_q.delete();
      b_q.delete();
   endtask

   task automatic push_tail();
      push_q.push_back({2'b11, 16'($urandom)});
      push_q.push_back(18'h0);
   endtask

   task automatic wait_drain(input int budget);
      int i = 0;
      while (exp_q.size() > 0 && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   task automatic rand_frame(input bit ur);
      int nw;
      logic [7:0] hi, lo;
      nw = ur ? $urandom_range(1, 6) : $urandom_range(0, 6);
      for (int k = 0; k < nw; k++) begin
         hi = 8'($urandom);
         lo = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            w_q.push_back({2'b11, hi, lo});
            b_q.push_back(hi);
            b_q.push_back(lo);
         end else begin
            w_q.push_back({2'b10, hi, lo});
            b_q.push_back(hi);
         end
      end
      if (!ur) w_q.push_back({2'b00, 16'($urandom)});
   endtask

   typedef struct packed {
      logic [3:0]        nw;
      logic [7:0][17:0]  w;
      logic [4:0]        nb;
      logic [15:0][7:0]  b;
      logic              ur;
   } vec_t;

   vec_t tbl[5];

   initial begin
      for (int i = 0; i < 5; i++) tbl[i] = '0;
      tbl[0].nw = 4'd3; tbl[0].w[0] = 18'h3AABB; tbl[0].w[1] = 18'h2CC00; tbl[0].w[2] = 18'h00000;
      tbl[0].nb = 5'd3; tbl[0].b[0] = 8'hAA; tbl[0].b[1] = 8'hBB; tbl[0].b[2] = 8'hCC;
      tbl[1].nw = 4'd1; tbl[1].w[0] = 18'h30102;
      tbl[1].nb = 5'd2; tbl[1].b[0] = 8'h01; tbl[1].b[1] = 8'h02; tbl[1].ur = 1'b1;
      tbl[2].nw = 4'd1; tbl[2].w[0] = 18'h00000; tbl[2].nb = 5'd0;
      tbl[3].nw = 4'd4; tbl[3].w[0] = 18'h21100; tbl[3].w[1] = 18'h22200;
      tbl[3].w[2] = 18'h33344; tbl[3].w[3] = 18'h00000;
      tbl[3].nb = 5'd4; tbl[3].b[0] = 8'h11; tbl[3].b[1] = 8'h22; tbl[3].b[2] = 8'h33; tbl[3].b[3] = 8'h44;
      tbl[4].nw = 4'd4; tbl[4].w[0] = 18'h3DEAD; tbl[4].w[1] = 18'h3BEEF;
      tbl[4].w[2] = 18'h27700; tbl[4].w[3] = 18'h35566;
      tbl[4].nb = 5'd7; tbl[4].b[0] = 8'hDE; tbl[4].b[1] = 8'hAD; tbl[4].b[2] = 8'hBE;
      tbl[4].b[3] = 8'hEF; tbl[4].b[4] = 8'h77; tbl[4].b[5] = 8'h55; tbl[4].b[6] = 8'h66;
      tbl[4].ur = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_tx_en", 64'(tx_en), 64'd0);
      check("rst_tx_er", 64'(tx_er), 64'd0);
      check("rst_txd", 64'(txd), 64'd0);
      check("rst_tx_count", 64'(tx_count), 64'd0);
      check("rst_underrun_count", 64'(underrun_count), 64'd0);
      check("rst_rd_en", 64'(rd_en), 64'd0);
      rst_n  = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);

      // directed frame table
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < int'(tbl[i].nw); k++) w_q.push_back(tbl[i].w[k]);
         for (int k = 0; k < int'(tbl[i].nb); k++) b_q.push_back(tbl[i].b[k]);
         send(rand_ts(), tbl[i].ur, 0);
         wait_drain(500);
         if (tbl[i].ur) push_tail();
         repeat (2) @(negedge clk);
         check("tbl_tx_count", 64'(tx_count), 64'(good_cnt));
         check("tbl_underrun_count", 64'(underrun_count), 64'(ur_cnt));
      end

      // two frames queued together: IFG countdown plus IDLE, 4 header pops and WAIT
      for (int f = 0; f < 2; f++) begin
         w_q.push_back(18'h31234); w_q.push_back(18'h00000);
         b_q.push_back(8'h12); b_q.push_back(8'h34);
         send(rand_ts(), 1'b0, 0);
      end
      wait_drain(500);
      check("b2b_gap_min", 64'(last_gap >= int'(IFG)), 64'd1);
      check("b2b_gap_exact", 64'(last_gap), 64'(int'(IFG) + 7));

      // reset while the lo byte of a word is being driven
      mon_on = 1'b0;
      push_q.push_back(18'h30000); push_q.push_back(18'h30000);
      push_q.push_back(18'h30000); push_q.push_back(18'h30000);
      push_q.push_back(18'h3A1A2); push_q.push_back(18'h3A3A4); push_q.push_back(18'h00000);
      begin
         int t = 0;
         while (!(tx_en && txd == 8'hA1) && t < 300) begin
            @(negedge clk);
            t++;
         end
         check("reset_target_reached", 64'(tx_en && txd == 8'hA1), 64'd1);
      end
      rst_n = 1'b0;
      #1;
      check("async_rst_tx_en", 64'(tx_en), 64'd0);
      check("async_rst_tx_er", 64'(tx_er), 64'd0);
      check("async_rst_txd", 64'(txd), 64'd0);
      fifo_q.delete();
      push_q.delete();
      exp_q.delete();
      good_cnt = 8'd0;
      ur_cnt   = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_mid_tx_count", 64'(tx_count), 64'd0);
      rst_n  = 1'b1;
      mon_on = 1'b1;
      for (int k = 0; k < int'(tbl[0].nw); k++) w_q.push_back(tbl[0].w[k]);
      for (int k = 0; k < int'(tbl[0].nb); k++) b_q.push_back(tbl[0].b[k]);
      send(rand_ts(), 1'b0, 0);
      wait_drain(500);
      check("post_rst_tx_count", 64'(tx_count), 64'(good_cnt));

`ifdef TIMED_LAUNCH_EN
      begin
         logic [63:0] g0;
         int t;
         gc_val = 64'd900;
         gc_set = 1'b1;
         w_q.push_back(18'h3AABB); w_q.push_back(18'h00000);
         b_q.push_back(8'hAA); b_q.push_back(8'hBB);
         send(64'd1000, 1'b0, 0);
         t = 0;
         while (!tx_en && t < 500) begin @(negedge clk); t++; end
         check("timed_launch_gc", gc, 64'd1002);
         wait_drain(500);
         repeat (20) @(negedge clk);
         g0 = gc;
         w_q.push_back(18'h3AABB); w_q.push_back(18'h00000);
         b_q.push_back(8'hAA); b_q.push_back(8'hBB);
         send(64'd10, 1'b0, 0);
         t = 0;
         while (!tx_en && t < 500) begin @(negedge clk); t++; end
         check("past_ts_launch_latency", gc - g0, 64'd8);
         wait_drain(500);
      end
`endif

      // tx_count wrap
      while (good_cnt != 8'hFF) begin
         w_q.push_back(18'h00000);
         send(rand_ts(), 1'b0, 0);
      end
      wait_drain(20000);
      check("tx_count_255", 64'(tx_count), 64'(good_cnt));
      w_q.push_back(18'h00000);
      send(rand_ts(), 1'b0, 0);
      wait_drain(500);
      check("tx_count_wrap", 64'(tx_count), 64'(good_cnt));

      // underrun_count saturation
      for (int i = 0; i < 300; i++) begin
         w_q.push_back(18'h30102);
         b_q.push_back(8'h01); b_q.push_back(8'h02);
         send(rand_ts(), 1'b1, 0);
         wait_drain(300);
         push_tail();
         if (i == 253 || i == 299) begin
            @(negedge clk);
            check("underrun_count_sat", 64'(underrun_count), 64'(ur_cnt));
         end
      end

      // random frames, stray words, header stalls, back-to-back or spaced
      for (int f = 0; f < 40; f++) begin
         bit ur;
         ur = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0)
            push_q.push_back({($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00, 16'($urandom)});
         rand_frame(ur);
         send(rand_ts(), ur, 3);
         if (ur) begin
            wait_drain(2000);
            push_tail();
         end else if ($urandom_range(0, 1) == 1) begin
            wait_drain(2000);
         end
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_drain(4000);
      repeat (40) @(negedge clk);
      check("rand_tx_count", 64'(tx_count), 64'(good_cnt));
      check("rand_underrun_count", 64'(underrun_count), 64'(ur_cnt));
      check("fifo_fully_consumed", 64'(fifo_q.size() + push_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #700000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
